// File: rtl/core_config_pkg.sv
// core_config: shared AXI widths, response/burst encodings and the request
// record latched by AXI responders.
//   ADDR_WIDTH / AXI_DATA_WIDTH / AXI_ID_WIDTH : bus geometry
//   AXI_RESP_*  : xRESP encodings
//   axi_burst_t : AxBURST encodings
//   axi_req_t   : latched AR/AW fields
//   sram_state_t: axi_sram_slave FSM states
package core_config;
  localparam int ADDR_WIDTH     = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [7:0]              len;
    logic [2:0]              size;
    axi_burst_t              burst;
  } axi_req_t;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP
  } sram_state_t;
endpackage

// File: rtl/axi_interface.sv
// axi_interface: full AXI4 bundle (AR/R/AW/W/B) with master and slave views.
interface axi_interface;
  import core_config::*;
  logic [AXI_ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]       araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid, arready;
  logic [AXI_ID_WIDTH-1:0]     rid;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rlast, rvalid, rready;
  logic [AXI_ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]       awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid, awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast, wvalid, wready;
  logic [AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                  bresp;
  logic                        bvalid, bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address and SRAM window decode.
//   addr/size/burst : current beat
//   next_addr       : address of the following beat (wraps mod 2^ADDR_WIDTH)
//   in_range        : BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*bytes/word
//   burst_err       : reserved burst encoding
//   word_addr       : SRAM word index of addr
module axi_burst_addr_gen
  import core_config::*;
#(
  parameter int                    MEM_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [2:0]                   size,
  input  axi_burst_t                   burst,
  output logic [ADDR_WIDTH-1:0]        next_addr,
  output logic                         in_range,
  output logic                         burst_err,
  output logic [$clog2(MEM_DEPTH)-1:0] word_addr
);
  localparam int LSB = $clog2(AXI_DATA_WIDTH/8);
  localparam int MW  = $clog2(MEM_DEPTH);
  // One extra bit so a window ending exactly at 2^ADDR_WIDTH still compares right.
  localparam logic [ADDR_WIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_DEPTH * (AXI_DATA_WIDTH/8));

  logic [ADDR_WIDTH-1:0] offset;
  assign offset    = addr - BASE_ADDR;
  assign in_range  = (addr >= BASE_ADDR) && ({1'b0, addr} < LIMIT);
  assign word_addr = offset[LSB +: MW];
  assign burst_err = (burst == AXI_BURST_RSVD);

  // WRAP is served as INCR; FIXED and reserved hold the address.
  always_comb begin
    next_addr = addr;
    if (burst == AXI_BURST_INCR || burst == AXI_BURST_WRAP)
      next_addr = addr + (ADDR_WIDTH'(1) << size);
  end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: one-transaction-at-a-time AXI4 responder in front of a
// word-wide synchronous SRAM with 1-cycle read latency.
//   clk, rst  : clock, async active-high reset
//   s_axi     : AXI4 slave port
//   mem_en    : SRAM access enable
//   mem_we    : per-byte write enable (0 = read)
//   mem_addr  : SRAM word address
//   mem_wdata : SRAM write data
//   mem_rdata : SRAM read data, valid the cycle after a read enable
module axi_sram_slave
  import core_config::*;
#(
  parameter int                    MEM_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                    ID        = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_interface.slave                  s_axi,
  output logic                         mem_en,
  output logic [AXI_DATA_WIDTH/8-1:0]  mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [AXI_DATA_WIDTH-1:0]    mem_wdata,
  input  logic [AXI_DATA_WIDTH-1:0]    mem_rdata
);
  sram_state_t                 state;
  axi_req_t                    req_q;
  logic [7:0]                  beat_q;
  logic                        prio_wr, err_q, dec_q, rd_first;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, beat_data;
  logic [ADDR_WIDTH-1:0]       next_addr;
  logic                        in_range, burst_err, access_ok, last_beat;
  logic                        idle, ar_go, aw_go, w_go;
  logic [1:0]                  beat_resp;

  axi_burst_addr_gen #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_addr_gen (
    .addr      (req_q.addr),
    .size      (req_q.size),
    .burst     (req_q.burst),
    .next_addr (next_addr),
    .in_range  (in_range),
    .burst_err (burst_err),
    .word_addr (mem_addr)
  );

  // Arbitration: only in IDLE; on a tie prio_wr picks the side.
  assign idle          = (state == IDLE);
  assign s_axi.arready = idle && s_axi.arvalid && (!s_axi.awvalid || !prio_wr);
  assign s_axi.awready = idle && s_axi.awvalid && (!s_axi.arvalid ||  prio_wr);
  assign ar_go         = s_axi.arvalid && s_axi.arready;
  assign aw_go         = s_axi.awvalid && s_axi.awready;
  assign w_go          = (state == WR_DATA) && s_axi.wvalid;

  assign access_ok = in_range && !burst_err;
  assign last_beat = (beat_q == req_q.len);
  assign beat_resp = !in_range ? AXI_RESP_DECERR :
                     burst_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign beat_data = access_ok ? mem_rdata : '0;

  // mem_rdata is only guaranteed in the first RD_DATA cycle; afterwards the
  // captured copy keeps rdata stable through backpressure.
  assign s_axi.rvalid = (state == RD_DATA);
  assign s_axi.rlast  = s_axi.rvalid && last_beat;
  assign s_axi.rresp  = s_axi.rvalid ? beat_resp : AXI_RESP_OKAY;
  assign s_axi.rdata  = rd_first ? beat_data : rdata_q;
  assign s_axi.rid    = req_q.id;

  assign s_axi.wready = (state == WR_DATA);
  assign s_axi.bvalid = (state == WR_RESP);
  assign s_axi.bid    = req_q.id;
  assign s_axi.bresp  = !s_axi.bvalid ? AXI_RESP_OKAY   :
                        dec_q         ? AXI_RESP_DECERR :
                        err_q         ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  assign mem_en    = access_ok && ((state == RD_REQ) || w_go);
  assign mem_we    = (w_go && access_ok) ? s_axi.wstrb : '0;
  assign mem_wdata = s_axi.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= '0;
      beat_q   <= '0;
      prio_wr  <= 1'b0;
      err_q    <= 1'b0;
      dec_q    <= 1'b0;
      rd_first <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_first <= 1'b0;
      case (state)
        IDLE: begin
          beat_q <= '0;
          err_q  <= 1'b0;
          dec_q  <= 1'b0;
          // A tie always produces a grant, so flip on every tie.
          if (s_axi.arvalid && s_axi.awvalid) prio_wr <= ~prio_wr;
          if (ar_go) begin
            req_q <= '{id: s_axi.arid, addr: s_axi.araddr, len: s_axi.arlen,
                       size: s_axi.arsize, burst: axi_burst_t'(s_axi.arburst)};
            state <= RD_REQ;
          end else if (aw_go) begin
            req_q <= '{id: s_axi.awid, addr: s_axi.awaddr, len: s_axi.awlen,
                       size: s_axi.awsize, burst: axi_burst_t'(s_axi.awburst)};
            state <= WR_DATA;
          end
        end
        RD_REQ: begin
          rd_first <= 1'b1;
          state    <= RD_DATA;
        end
        RD_DATA: begin
          if (rd_first) rdata_q <= beat_data;
          if (s_axi.rready) begin
            if (last_beat) state <= IDLE;
            else begin
              beat_q     <= beat_q + 8'd1;
              req_q.addr <= next_addr;
              state      <= RD_REQ;
            end
          end
        end
        WR_DATA: begin
          if (s_axi.wvalid) begin
            if (!in_range) dec_q <= 1'b1;
            if (burst_err || (s_axi.wlast != last_beat)) err_q <= 1'b1;
            req_q.addr <= next_addr;
            // Length comes from AWLEN; a misplaced wlast only flags an error.
            if (last_beat) state <= WR_RESP;
            else beat_q <= beat_q + 8'd1;
          end
        end
        WR_RESP: if (s_axi.bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: table-driven AXI transactions against a reference memory
// model, with R/B scoreboards, plus hand sequences for arbitration, stalls,
// reserved bursts and reset mid-burst.
module tb_axi_sram_slave;
  import core_config::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_interface axi();
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  axi_sram_slave #(.MEM_DEPTH(1024), .BASE_ADDR(32'h0), .ID(0)) dut (
    .clk(clk), .rst(rst), .s_axi(axi), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] pat(input int i);
    if (i == 0) return 32'hAAAA_AAAA;
    if (i == 4) return 32'hDEAD_BEEF;
    return {16'hC0DE, 16'(i)};
  endfunction

  // SRAM model driven by the DUT, plus an independent expected image.
  logic [31:0] sram    [1024];
  logic [31:0] ref_mem [1024];
  logic        loaded = 1'b0;
  int          wr_cnt = 0;
  int          cyc    = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) sram[i] <= pat(i);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we == 4'h0) mem_rdata <= sram[mem_addr];
      else begin
        wr_cnt <= wr_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  localparam int W_AR = 0, W_AW = 1, W_R = 2, W_W = 3, W_B = 4;
  task automatic wait_hi(input int sel, input string nm, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      case (sel)
        W_AR:    ok = axi.arready;
        W_AW:    ok = axi.awready;
        W_R:     ok = axi.rvalid;
        W_W:     ok = axi.wready;
        default: ok = axi.bvalid;
      endcase
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL timeout %s: got never-high expected high within 64 cycles", nm);
    end
  endtask

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [2:0] sz,
                                        input logic [1:0] bu, input int i);
    if (bu == 2'b00 || bu == 2'b11) return a;
    return a + (32'(i) << sz);
  endfunction
  function automatic logic [1:0] eresp(input logic [31:0] a, input logic [1:0] bu);
    if (a >= 32'h1000) return 2'b11;
    if (bu == 2'b11)   return 2'b10;
    return 2'b00;
  endfunction

  typedef struct { logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id; } rexp_t;
  typedef struct { logic [1:0] r; logic [3:0] id; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    bit ok; int hs; bit first; logic [31:0] a; rexp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      a = baddr(addr, size, burst, i);
      e.r = eresp(a, burst);
      e.d = (e.r == 2'b00) ? ref_mem[a[11:2]] : 32'h0;
      e.l = (i == int'(len));
      e.id = id;
      rq.push_back(e);
    end
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    axi.arvalid = 1'b1;
    wait_hi(W_AR, "arready", ok);
    hs = cyc;
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    if (!ok) begin rq.delete(); return; end
    axi.rready = 1'b1;
    first = 1'b1;
    while (rq.size() > 0) begin
      wait_hi(W_R, "rvalid", ok);
      if (!ok) begin rq.delete(); break; end
      if (first) chk("rd_latency", 64'(cyc - hs), 64'd2);
      first = 1'b0;
      e = rq.pop_front();
      chk("rd_beat", {axi.rdata, axi.rresp, axi.rlast, axi.rid}, {e.d, e.r, e.l, e.id});
      @(posedge clk); #1;
    end
    axi.rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [3:0] strb,
                          input logic [31:0] d0, input int wl, input logic [1:0] eb,
                          input bit granted);
    bit ok; logic [31:0] a, dd; bexp_t be;
    for (int i = 0; i <= int'(len); i++) begin
      a  = baddr(addr, size, burst, i);
      dd = d0 + 32'(i);
      if (eresp(a, burst) == 2'b00)
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[a[11:2]][8*b +: 8] = dd[8*b +: 8];
    end
    be.r = eb; be.id = id;
    bq.push_back(be);
    if (!granted) begin
      axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
      axi.awvalid = 1'b1;
      wait_hi(W_AW, "awready", ok);
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      if (!ok) begin bq.delete(); return; end
    end
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata = d0 + 32'(i); axi.wstrb = strb; axi.wlast = (i == wl); axi.wvalid = 1'b1;
      wait_hi(W_W, "wready", ok);
      @(posedge clk); #1;
      if (!ok) break;
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    axi.bready = 1'b1;
    wait_hi(W_B, "bvalid", ok);
    if (ok) begin
      be = bq.pop_front();
      chk("bresp_bid", {axi.bresp, axi.bid}, {be.r, be.id});
    end else bq.delete();
    @(posedge clk); #1;
    axi.bready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [3:0]  strb;
    logic [31:0] d0;
    int          wl;
    logic [1:0]  eb;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    bit ok;
    int wc;
    logic [34:0] snap;

    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    axi.arvalid = 0; axi.awvalid = 0; axi.wvalid = 0; axi.rready = 0; axi.bready = 0;
    axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
    axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
    axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;

    //          wr    addr           len    size  burst  id     strb   d0             wl eb
    vt.push_back('{1'b0, 32'h10,       8'd0,  3'd2, 2'b01, 4'd3,  4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b1, 32'h20,       8'd3,  3'd2, 2'b01, 4'd1,  4'hF,  32'h1,         3, 2'b00});
    vt.push_back('{1'b0, 32'h20,       8'd3,  3'd2, 2'b01, 4'd2,  4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b1, 32'h0,        8'd0,  3'd2, 2'b01, 4'd4,  4'h3,  32'h1234_5678, 0, 2'b00});
    vt.push_back('{1'b0, 32'h0,        8'd0,  3'd2, 2'b01, 4'd5,  4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b0, 32'h1000,     8'd0,  3'd2, 2'b01, 4'd6,  4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b1, 32'h60,       8'd1,  3'd2, 2'b01, 4'd7,  4'hF,  32'h70,        0, 2'b10});
    vt.push_back('{1'b0, 32'h60,       8'd1,  3'd2, 2'b01, 4'd8,  4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b1, 32'hFFC,      8'd1,  3'd2, 2'b01, 4'd9,  4'hF,  32'h90,        1, 2'b11});
    vt.push_back('{1'b0, 32'hFFC,      8'd1,  3'd2, 2'b01, 4'd10, 4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b0, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 4'd11, 4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b0, 32'h24,       8'd2,  3'd2, 2'b00, 4'd12, 4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b1, 32'h30,       8'd2,  3'd2, 2'b00, 4'd13, 4'hF,  32'h100,       2, 2'b00});
    vt.push_back('{1'b0, 32'h30,       8'd0,  3'd2, 2'b01, 4'd14, 4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b0, 32'h8,        8'd3,  3'd0, 2'b01, 4'd15, 4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b0, 32'h0,        8'd255, 3'd2, 2'b01, 4'd0, 4'h0,  32'h0,         0, 2'b00});
    vt.push_back('{1'b0, 32'h40,       8'd1,  3'd2, 2'b11, 4'd1,  4'h0,  32'h0,         0, 2'b00});

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {axi.arready, axi.awready, axi.wready, axi.rvalid, axi.rlast, axi.bvalid,
                       mem_en, mem_we}, 11'h0);
    chk("reset_data", {axi.rdata, axi.rresp, axi.bresp}, 36'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", {axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid, mem_en}, 6'h0);
    @(posedge clk); #1;

    foreach (vt[k]) begin
      if (vt[k].wr)
        do_write(vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, vt[k].id, vt[k].strb,
                 vt[k].d0, vt[k].wl, vt[k].eb, 1'b0);
      else
        do_read(vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, vt[k].id);
    end

    chk("strobe_word0", 64'(sram[0]), 64'h0000_0000_AAAA_5678);
    for (int i = 8; i < 12; i++) chk("incr_words", 64'(sram[i]), 64'(i - 7));
    chk("wlast_err_w0", 64'(sram[24]), 64'h70);
    chk("wlast_err_w1", 64'(sram[25]), 64'h71);
    chk("decerr_w_in",  64'(sram[1023]), 64'h90);
    chk("fixed_w_last", 64'(sram[12]), 64'h102);

    // simultaneous AR/AW: read wins first, then held under backpressure
    axi.arid = 4'd5; axi.araddr = 32'h10; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'b01;
    axi.awid = 4'd6; axi.awaddr = 32'h50; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'b01;
    axi.arvalid = 1'b1; axi.awvalid = 1'b1;
    @(negedge clk);
    chk("arb1_grant", {axi.arready, axi.awready}, 2'b10);
    @(posedge clk); #1;
    axi.arvalid = 1'b0; axi.awvalid = 1'b0;
    wait_hi(W_R, "rvalid_stall", ok);
    if (ok) begin
      chk("stall_first", {axi.rdata, axi.rresp, axi.rlast, axi.rid},
          {32'hDEAD_BEEF, 2'b00, 1'b1, 4'd5});
      snap = {axi.rdata, axi.rresp, axi.rlast};
      repeat (5) begin
        @(negedge clk);
        chk("stall_hold", {axi.rvalid, axi.rdata, axi.rresp, axi.rlast}, {1'b1, snap});
      end
      axi.rready = 1'b1;
      @(posedge clk); #1;
      axi.rready = 1'b0;
      @(negedge clk);
      chk("stall_done", axi.rvalid, 1'b0);
    end
    @(posedge clk); #1;
    axi.arvalid = 1'b1; axi.awvalid = 1'b1;
    @(negedge clk);
    chk("arb2_grant", {axi.arready, axi.awready}, 2'b01);
    @(posedge clk); #1;
    axi.arvalid = 1'b0; axi.awvalid = 1'b0;
    do_write(32'h50, 8'd0, 3'd2, 2'b01, 4'd6, 4'hF, 32'h5A5A_5A5A, 0, 2'b00, 1'b1);
    chk("arb2_sram", 64'(sram[20]), 64'h5A5A_5A5A);

    // reserved burst write: SLVERR, no SRAM write
    wc = wr_cnt;
    do_write(32'h40, 8'd1, 3'd2, 2'b11, 4'd2, 4'hF, 32'hBAD0, 1, 2'b10, 1'b0);
    chk("rsvd_no_write", 64'(wr_cnt), 64'(wc));
    chk("rsvd_mem", 64'(sram[16]), 64'(pat(16)));

    // reset during the second beat of an 8-beat read
    axi.arid = 4'd9; axi.araddr = 32'h20; axi.arlen = 8'd7; axi.arsize = 3'd2; axi.arburst = 2'b01;
    axi.arvalid = 1'b1;
    wait_hi(W_AR, "arready_rst", ok);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    wait_hi(W_R, "rvalid_rst0", ok);
    @(posedge clk); #1;
    wait_hi(W_R, "rvalid_rst1", ok);
    rst = 1'b1;
    #1;
    chk("rst_mid_out", {axi.rvalid, axi.rlast, mem_en}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    axi.rready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_quiet", {axi.rvalid, mem_en}, 2'b00);
    end
    @(posedge clk); #1;
    do_read(32'h20, 8'd3, 3'd2, 2'b01, 4'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder (slave end) that bridges the core's AXI master ports (dcache/icache masters) to a word-wide synchronous SRAM with 1-cycle read latency.
- Used as the on-chip data RAM behind the crossbar and as the memory model in core-level benches.
- Serves one transaction at a time:
  - reads: FIXED/INCR bursts, length 1..256;
  - writes: same bursts, with byte strobes.
- Returns OKAY, SLVERR or DECERR responses.

Parameters:
- MEM_DEPTH, 1024, number of AXI_DATA_WIDTH-bit SRAM words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to SRAM word 0.
- ID, 0, unused for decode; ids are echoed from the request.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- s_axi  interface  axi_interface.slave  full AXI4 slave side: AR/R/AW/W/B channels; ADDR_WIDTH/AXI_DATA_WIDTH from core_config
- mem_en  output  1  SRAM access enable
- mem_we  output  AXI_DATA_WIDTH/8  per-byte write enable; 0 means read
- mem_addr  output  $clog2(MEM_DEPTH)  SRAM word address
- mem_wdata  output  AXI_DATA_WIDTH  SRAM write data
- mem_rdata  input  AXI_DATA_WIDTH  SRAM read data, valid the cycle after mem_en with mem_we==0

Behaviour:
- Reset values (async, rst=1):
  - state=IDLE; arready, awready, wready, rvalid, rlast, bvalid, mem_en = 0; mem_we = 0.
  - rresp=bresp=2'b00; rdata=0; prio_wr=0.
  - Reset mid-burst abandons the transaction; no further SRAM access is issued.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE arbitration:
  - arready and awready are combinational and only ever high in IDLE.
  - With only arvalid high: arready=1. With only awvalid high: awready=1.
  - With both high: grant the read if prio_wr==0, else the write. Toggle prio_wr after every simultaneous grant (alternating, no starvation).
- On handshake, latch: id, addr, len, size, burst; beat counter=0; err flag=0.
  - Go to RD_REQ for a read, WR_DATA for a write.
- Address decode:
  - in range iff BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*(AXI_DATA_WIDTH/8);
  - mem_addr = (addr-BASE_ADDR) >> $clog2(AXI_DATA_WIDTH/8).
  - Decode is checked per beat; any out-of-range beat is DECERR.
- Next address:
  - FIXED (2'b00): unchanged.
  - INCR (2'b01): addr + (1<<size).
  - WRAP (2'b10): treated as INCR.
  - Reserved (2'b11): SLVERR for every beat and no SRAM access.
- RD_REQ:
  - mem_en=1, mem_we=0 if in range (else no access); next state RD_DATA.
- RD_DATA:
  - rvalid=1; rdata = captured mem_rdata (0 if out of range); rresp = 00 / 11 (DECERR) / 10 (SLVERR); rid = latched id; rlast = (beat==len).
  - rdata/rresp/rlast are held stable while rready=0.
  - On rready: if rlast go to IDLE, else beat++, advance address, go to RD_REQ.
  - Throughput is 1 beat per 2 cycles.
  - Latency: AR handshake in cycle N gives first rvalid in cycle N+2.
- Narrow transfers: the full word is returned; the master selects lanes. Writes rely on wstrb.
- WR_DATA:
  - wready=1. On wvalid: mem_en=1, mem_we=wstrb (0 if out of range or reserved burst), mem_wdata=wdata.
  - Advance address. If wlast != (beat==len), set err (SLVERR).
  - The burst ends when beat==len regardless of wlast; go to WR_RESP.
- WR_RESP:
  - bvalid=1; bid = latched id; bresp = DECERR if any beat was out of range, else SLVERR if err, else OKAY.
  - Held until bready; then IDLE.
- Beat counter is 8 bits; len=255 gives 256 beats with no wrap. Address arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.

Decomposition:
- core_config package:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11;
  - AXI_BURST_FIXED/INCR/WRAP;
  - typedef axi_burst_t.
- Sub-module axi_burst_addr_gen (combinational next-address plus in-range decode), shared with future slaves. The FSM stays in axi_sram_slave.

Test Plan (AXI_DATA_WIDTH=32, BASE_ADDR=0):
- Single read: SRAM word 4 = 32'hDEADBEEF; AR addr=0x10, len=0, id=3, handshake cycle N -> rvalid at N+2, rdata=32'hDEADBEEF, rresp=00, rlast=1, rid=3.
- INCR burst: write addr=0x20, len=3, size=2, data 1..4, wstrb=4'hF -> bresp=00, words 8..11 = 1..4. Read back the same burst -> 1,2,3,4 with rlast only on beat 4.
- Strobes: word 0 = 32'hAAAAAAAA; write 32'h12345678 with wstrb=4'b0011 -> word 0 = 32'hAAAA5678.
- Arbitration: arvalid and awvalid rise together twice -> first grant read, second grant write. Hold rready=0 for 5 cycles -> rvalid/rdata/rlast stable.
- Errors:
  - read addr = MEM_DEPTH*4 -> rresp=11, rdata=0;
  - write len=1 with wlast on beat 1 -> 2 beats written, bresp=10;
  - burst=2'b11 -> SLVERR, memory unchanged.
- Reset mid-burst: assert rst during beat 2 of a len=7 read -> rvalid=0 immediately, state IDLE. A subsequent read returns correct data.
